// File: rtl/gpu_host_pkg.sv
// Shared definitions for the host command path into the GPU control register bank:
// opcodes, decoder state encoding and the default bus address width.
package gpu_host_pkg;

   localparam int DEFAULT_ADDR_W = 20;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam logic [7:0] OP_PING  = 8'h03;

   // ADDR2..WDATA are the states that take bytes from the host and can time out;
   // RREQ..PING wait on the register bank or on the host link.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_ADDR2 = 4'd1,
      ST_ADDR1 = 4'd2,
      ST_ADDR0 = 4'd3,
      ST_COUNT = 4'd4,
      ST_WDATA = 4'd5,
      ST_RREQ  = 4'd6,
      ST_RWAIT = 4'd7,
      ST_RSEND = 4'd8,
      ST_PING  = 4'd9
   } state_t;

endpackage

// File: rtl/host_cmd_decoder.sv
// Host byte-stream command decoder. Parses framed WRITE / READ / PING commands
// from the host link and turns them into single-cycle register-bank strobes,
// returning read data and ping replies on the tx byte stream.
module host_cmd_decoder
   import gpu_host_pkg::*;
#(
   parameter int         ADDR_W      = DEFAULT_ADDR_W,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter logic [7:0] PING_RESP   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              we,
   output logic              rd_req,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        wdata,
   input  logic [7:0]        rd_data,
   output logic              timeout_p,
   output logic              bad_op_p
);

   // The counter only has to reach TIMEOUT_CYC-1; the abort fires on the next idle clock.
   localparam int                TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;   // running address of the command
   logic [8:0]          rem_q, rem_d;             // bytes left in the command (1..256)
   logic                is_wr_q, is_wr_d;         // command is WRITE (else READ)
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                we_q, we_d;
   logic                rd_req_q, rd_req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                timeout_q, timeout_d;
   logic                bad_op_q, bad_op_d;

   logic                rx_fire;
   logic                tx_fire;
   logic                in_rx_state;

   assign in_rx_state = (state_q inside {ST_IDLE, ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_COUNT, ST_WDATA});
   assign rx_ready    = in_rx_state;
   assign rx_fire     = rx_valid && in_rx_state;
   assign tx_fire     = tx_valid_q && tx_ready;

   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign we        = we_q;
   assign rd_req    = rd_req_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign timeout_p = timeout_q;
   assign bad_op_p  = bad_op_q;

   // Next-state, strobe and timeout logic for the command parser.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      is_wr_d    = is_wr_q;
      to_cnt_d   = to_cnt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      rd_req_d   = 1'b0;
      timeout_d  = 1'b0;
      bad_op_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            to_cnt_d = '0;
            if (rx_fire) begin
               case (rx_data)
                  OP_WRITE: begin
                     is_wr_d = 1'b1;
                     state_d = ST_ADDR2;
                  end
                  OP_READ: begin
                     is_wr_d = 1'b0;
                     state_d = ST_ADDR2;
                  end
                  OP_PING: begin
                     tx_data_d  = PING_RESP;
                     tx_valid_d = 1'b1;
                     state_d    = ST_PING;
                  end
                  default: bad_op_d = 1'b1;
               endcase
            end
         end

         // Upper nibble of A2 is ignored; the byte lands in bits [19:16].
         ST_ADDR2: begin
            if (rx_fire) begin
               cur_addr_d = ADDR_W'({rx_data[3:0], 16'h0000});
               state_d    = ST_ADDR1;
            end
         end

         ST_ADDR1: begin
            if (rx_fire) begin
               cur_addr_d = cur_addr_q | ADDR_W'({rx_data, 8'h00});
               state_d    = ST_ADDR0;
            end
         end

         ST_ADDR0: begin
            if (rx_fire) begin
               cur_addr_d = cur_addr_q | ADDR_W'(rx_data);
               state_d    = ST_COUNT;
            end
         end

         // A count byte of zero encodes a 256-byte transfer.
         ST_COUNT: begin
            if (rx_fire) begin
               rem_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
               if (is_wr_q) begin
                  state_d = ST_WDATA;
               end else begin
                  rd_req_d = 1'b1;
                  addr_d   = cur_addr_q;
                  state_d  = ST_RREQ;
               end
            end
         end

         ST_WDATA: begin
            if (rx_fire) begin
               we_d       = 1'b1;
               wdata_d    = rx_data;
               addr_d     = cur_addr_q;
               cur_addr_d = cur_addr_q + ADDR_ONE;
               rem_d      = rem_q - 9'd1;
               if (rem_q == 9'd1) begin
                  state_d = ST_IDLE;
               end
            end
         end

         // rd_req is high during this state; data arrives in RWAIT.
         ST_RREQ: begin
            state_d = ST_RWAIT;
         end

         ST_RWAIT: begin
            tx_data_d  = rd_data;
            tx_valid_d = 1'b1;
            state_d    = ST_RSEND;
         end

         ST_RSEND: begin
            if (tx_fire) begin
               tx_valid_d = 1'b0;
               cur_addr_d = cur_addr_q + ADDR_ONE;
               rem_d      = rem_q - 9'd1;
               if (rem_q == 9'd1) begin
                  state_d = ST_IDLE;
               end else begin
                  rd_req_d = 1'b1;
                  addr_d   = cur_addr_q + ADDR_ONE;
                  state_d  = ST_RREQ;
               end
            end
         end

         ST_PING: begin
            if (tx_fire) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase

      // Inter-byte timeout: only while the host owes us bytes of an open command.
      if (state_q inside {ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_COUNT, ST_WDATA}) begin
         if (rx_fire) begin
            to_cnt_d = '0;
         end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d  = '0;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
         end else begin
            to_cnt_d = to_cnt_q + TO_ONE;
         end
      end
   end

   // State and output registers; reset drops any command in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         rem_q      <= '0;
         is_wr_q    <= 1'b0;
         to_cnt_q   <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         we_q       <= 1'b0;
         rd_req_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         timeout_q  <= 1'b0;
         bad_op_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         is_wr_q    <= is_wr_d;
         to_cnt_q   <= to_cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         we_q       <= we_d;
         rd_req_q   <= rd_req_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         timeout_q  <= timeout_d;
         bad_op_q   <= bad_op_d;
      end
   end

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Bench for host_cmd_decoder: directed frames plus random frame traffic, checked
// against a frame-level reference model of expected writes, reads and replies.
module tb_host_cmd_decoder;

   localparam int AW = 20;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          we;
   logic          rd_req;
   logic [AW-1:0] addr;
   logic [7:0]    wdata;
   logic [7:0]    rd_data = 8'h00;
   logic          timeout_p;
   logic          bad_op_p;

   host_cmd_decoder #(
      .ADDR_W      (AW),
      .TIMEOUT_CYC (TO),
      .PING_RESP   (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .we        (we),
      .rd_req    (rd_req),
      .addr      (addr),
      .wdata     (wdata),
      .rd_data   (rd_data),
      .timeout_p (timeout_p),
      .bad_op_p  (bad_op_p)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register bank read port: data is addr[7:0] one clock after rd_req, junk otherwise.
   always @(posedge clk) rd_data <= rd_req ? addr[7:0] : 8'hEE;

   // Host link sink: random or forced ready, changed just after the rising edge.
   bit   tx_auto  = 1'b0;
   logic tx_force = 1'b1;
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = tx_auto ? ($urandom_range(0, 3) != 0) : tx_force;
      end
   end

   // Observed events
   logic [27:0] act_wr[$];
   int          act_wr_cyc[$];
   logic [19:0] act_rd[$];
   logic [7:0]  act_tx[$];
   int          act_bad_n = 0, act_to_n = 0, act_to_cyc = 0;
   int          viol_excl = 0, viol_rxr = 0, viol_hold = 0;
   logic        prev_hold = 1'b0;
   logic [7:0]  prev_txd  = 8'h00;

   always @(negedge clk) begin
      if (we) begin
         act_wr.push_back({addr, wdata});
         act_wr_cyc.push_back(cyc);
      end
      if (rd_req) act_rd.push_back(addr);
      if (tx_valid && tx_ready) act_tx.push_back(tx_data);
      if (bad_op_p) act_bad_n <= act_bad_n + 1;
      if (timeout_p) begin
         act_to_n   <= act_to_n + 1;
         act_to_cyc <= cyc;
      end
      if (we && rd_req) viol_excl <= viol_excl + 1;
      if ((rd_req || tx_valid) && rx_ready) viol_rxr <= viol_rxr + 1;
      if (prev_hold && !rst && (!tx_valid || tx_data != prev_txd)) viol_hold <= viol_hold + 1;
      prev_hold <= tx_valid && !tx_ready && !rst;
      prev_txd  <= tx_data;
   end

   // Expected events (reference model output)
   logic [27:0] exp_wr[$];
   logic [19:0] exp_rd[$];
   logic [7:0]  exp_tx[$];
   int          exp_bad_n = 0, exp_to_n = 0;

   int base_wr = 0, base_rd = 0, base_tx = 0, base_bad = 0, base_to = 0;
   int base_excl = 0, base_rxr = 0, base_hold = 0;

   int total = 0;
   int bad   = 0;
   int last_acc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Frame-level model: what the register bank and host should see for one frame.
   task automatic model_frame(input logic [7:0] f[$]);
      logic [7:0]  op;
      logic [7:0]  b2, b1, b0, nb;
      logic [19:0] a, ra;
      int          n;
      op = f[0];
      if (op == 8'h01 || op == 8'h02) begin
         b2 = f[1]; b1 = f[2]; b0 = f[3]; nb = f[4];
         a  = {b2[3:0], b1, b0};
         n  = (nb == 8'h00) ? 256 : int'(nb);
         for (int k = 0; k < n; k++) begin
            ra = a + 20'(k);
            if (op == 8'h01) begin
               exp_wr.push_back({ra, f[5 + k]});
            end else begin
               exp_rd.push_back(ra);
               exp_tx.push_back(ra[7:0]);
            end
         end
      end else if (op == 8'h03) begin
         exp_tx.push_back(8'hA5);
      end else begin
         exp_bad_n++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         check("rx_accept_wait", n, 0);
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         last_acc = cyc;
         #1 rx_valid = 1'b0;
      end
   endtask

   task automatic send_bytes(input logic [7:0] f[$], input int gap_max);
      foreach (f[i]) begin
         send_byte(f[i]);
         if (gap_max > 0 && i != f.size() - 1) idle($urandom_range(0, gap_max));
      end
   endtask

   task automatic send_frame(input logic [7:0] f[$], input int gap_max);
      model_frame(f);
      $display("frame op=%02h len=%0d t=%0d", f[0], f.size(), cyc);
      send_bytes(f, gap_max);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (((act_tx.size() - base_tx) < exp_tx.size() ||
              (act_wr.size() - base_wr) < exp_wr.size()) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) check({tag, "_drain"}, n, 0);
      idle(6);
   endtask

   task automatic compare_all(input string tag);
      int nw, nr, nt;
      nw = act_wr.size() - base_wr;
      nr = act_rd.size() - base_rd;
      nt = act_tx.size() - base_tx;
      check({tag, "_wr_count"}, nw, exp_wr.size());
      for (int i = 0; i < nw && i < exp_wr.size(); i++)
         check({tag, "_wr_addr_data"}, act_wr[base_wr + i], exp_wr[i]);
      check({tag, "_rd_count"}, nr, exp_rd.size());
      for (int i = 0; i < nr && i < exp_rd.size(); i++)
         check({tag, "_rd_addr"}, act_rd[base_rd + i], exp_rd[i]);
      check({tag, "_tx_count"}, nt, exp_tx.size());
      for (int i = 0; i < nt && i < exp_tx.size(); i++)
         check({tag, "_tx_byte"}, act_tx[base_tx + i], exp_tx[i]);
      check({tag, "_bad_op"}, act_bad_n - base_bad, exp_bad_n);
      check({tag, "_timeout"}, act_to_n - base_to, exp_to_n);
      check({tag, "_we_rd_same_cycle"}, viol_excl - base_excl, 0);
      check({tag, "_rx_ready_in_read"}, viol_rxr - base_rxr, 0);
      check({tag, "_tx_hold"}, viol_hold - base_hold, 0);
      $display("section %s: writes=%0d reads=%0d tx=%0d", tag, nw, nr, nt);
      base_wr   = act_wr.size();
      base_rd   = act_rd.size();
      base_tx   = act_tx.size();
      base_bad  = act_bad_n;
      base_to   = act_to_n;
      base_excl = viol_excl;
      base_rxr  = viol_rxr;
      base_hold = viol_hold;
      exp_wr.delete();
      exp_rd.delete();
      exp_tx.delete();
      exp_bad_n = 0;
      exp_to_n  = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] frm[$];
      int         b, d, kind, n;
      logic [7:0] nb;

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_rx_ready", rx_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_we", we, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_addr", addr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_timeout_p", timeout_p, 0);
      check("rst_bad_op_p", bad_op_p, 0);
      rst = 1'b0;
      idle(2);

      // 1: single write, strobe one clock after the data byte
      frm = {8'h01, 8'h00, 8'h00, 8'h10, 8'h01, 8'h5A};
      b = act_wr.size();
      send_frame(frm, 0);
      idle(4);
      if (act_wr.size() > b) check("t1_we_timing", act_wr_cyc[b], last_acc + 1);
      else check("t1_we_seen", act_wr.size() - b, 1);
      check("t1_back_to_idle", rx_ready, 1);
      compare_all("t1");

      // 2: burst across the top of the address space, one write per clock
      frm = {8'h01, 8'h0F, 8'hFF, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33};
      b = act_wr.size();
      send_frame(frm, 0);
      idle(4);
      if (act_wr.size() >= b + 3) begin
         check("t2_consec_1", act_wr_cyc[b + 1] - act_wr_cyc[b], 1);
         check("t2_consec_2", act_wr_cyc[b + 2] - act_wr_cyc[b + 1], 1);
      end
      compare_all("t2");

      // 3: read of two bytes with the host holding off the first one
      tx_force = 1'b0;
      idle(2);
      frm = {8'h02, 8'h00, 8'h00, 8'h20, 8'h02};
      send_frame(frm, 0);
      n = 0;
      while (!tx_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t3_tx_valid_seen", tx_valid, 1);
      for (int i = 0; i < 5; i++) begin
         check("t3_tx_data_held", tx_data, 8'h20);
         check("t3_tx_valid_held", tx_valid, 1);
         @(negedge clk);
      end
      tx_force = 1'b1;
      wait_drain("t3");
      compare_all("t3");

      // 4: unknown opcode then ping
      frm = {8'h7E};
      send_frame(frm, 0);
      idle(3);
      frm = {8'h03};
      send_frame(frm, 0);
      wait_drain("t4");
      compare_all("t4");

      // 5: abandoned write header times out
      frm = {8'h01, 8'h00, 8'h00};
      $display("frame op=01 len=3 (truncated) t=%0d", cyc);
      send_bytes(frm, 0);
      d = last_acc;
      idle(TO + 6);
      exp_to_n = 1;
      check("t5_timeout_latency_ok",
            ((act_to_cyc - d) >= TO && (act_to_cyc - d) <= TO + 2) ? 1 : 0, 1);
      frm = {8'h03};
      send_frame(frm, 0);
      wait_drain("t5");
      compare_all("t5");

      // 6: reset in the middle of a write burst
      frm = {8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'hAA, 8'hBB};
      $display("frame op=01 len=7 (cut by reset) t=%0d", cyc);
      send_bytes(frm, 0);
      exp_wr.push_back({20'h00000, 8'hAA});
      exp_wr.push_back({20'h00001, 8'hBB});
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_rx_ready_after_rst", rx_ready, 1);
      check("t6_we_after_rst", we, 0);
      frm = {8'hCC};
      send_frame(frm, 0);
      idle(6);
      compare_all("t6");

      // Random frame traffic with random gaps and random host backpressure
      tx_auto = 1'b1;
      for (int f = 0; f < 48; f++) begin
         kind = $urandom_range(0, 7);
         if (kind <= 2 || kind == 7) begin
            nb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 6));
            frm = {8'h01, 8'($urandom), 8'($urandom), 8'($urandom), nb};
            if (kind == 7) frm[1] = 8'($urandom_range(0, 255)) | 8'h0F;
            n = (nb == 8'h00) ? 256 : int'(nb);
            for (int k = 0; k < n; k++) frm.push_back(8'($urandom));
         end else if (kind <= 4) begin
            frm = {8'h02, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 4))};
         end else if (kind == 5) begin
            frm = {8'h03};
         end else begin
            nb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(4, 255));
            frm = {nb};
         end
         send_frame(frm, 3);
         if ((f % 12) == 11) begin
            wait_drain("rand");
            compare_all("rand");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
